sm_uart_word_tx: RTL and testbench
==================================

SM_UART_WORD_TX -- requirements
Module: sm_uart_word_tx

Interface
REQ-001 Parameter CLK_HZ, default 100000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate.
REQ-003 Parameter NEWLINE, default 1; when 1, CR (0x0D) then LF (0x0A) SHALL follow each word.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 word_i  input  32  word to transmit, sampled on acceptance.
REQ-007 valid_i  input  1  word_i valid request.
REQ-008 ready_o  output  1  block idle, can accept a word.
REQ-009 tx_o  output  1  UART serial line, 8N1, idle high.
REQ-010 busy_o  output  1  transmission in progress; always the inverse of ready_o.

Function
REQ-011 Bit period SHALL be BAUD_DIV = CLK_HZ/BAUD cycles (integer truncation; 868 at defaults); BAUD_DIV < 2 is illegal.
REQ-012 Acceptance SHALL occur on a rising edge with valid_i=1 and ready_o=1; word_i is latched at that edge; ready_o SHALL be 0 from the next cycle.
REQ-013 valid_i while ready_o=0 SHALL be ignored; no queuing.
REQ-014 The word SHALL be sent as 8 uppercase ASCII hex characters, most significant nibble first (bits 31:28 first).
REQ-015 Nibble mapping: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46.
REQ-016 Each character frame: start bit (0), 8 data bits LSB first, one stop bit (1); each bit held exactly BAUD_DIV cycles.
REQ-017 The start bit of the first character SHALL appear on tx_o the cycle after acceptance.
REQ-018 Characters SHALL be back-to-back: the next start bit begins the cycle after the previous stop bit ends; no idle gap.
REQ-019 Total busy time SHALL be N*10*BAUD_DIV cycles, N = 10 (NEWLINE=1) or 8 (NEWLINE=0).
REQ-020 ready_o SHALL reassert the cycle after the final stop bit completes; a word can be accepted that same cycle, so back-to-back words have no gap.
REQ-021 States: IDLE -> START -> DATA (8 bits) -> STOP -> START (characters remain) or IDLE (last character).
REQ-022 tx_o SHALL be registered (no combinational path from inputs), and SHALL be 1 in IDLE and STOP.

Reset
REQ-023 On rst=1 at a clock edge: state IDLE, tx_o=1, ready_o=1, busy_o=0, all counters 0.
REQ-024 Reset mid-transmission SHALL abort immediately; tx_o=1 from the following cycle; the partial character is not resumed.
REQ-025 rst SHALL take priority over simultaneous valid_i; that word is not accepted.

Structure
REQ-026 Package sm_uart_pkg SHALL hold the BAUD_DIV calculation function, ASCII constants (0x30, 0x41, 0x0D, 0x0A), and the state enumeration.
REQ-027 One sub-module, sm_uart_tx_byte, SHALL serialise a single byte with its own start/done handshake; sm_uart_word_tx sequences characters into it.

Verification (simulate with CLK_HZ/BAUD chosen so BAUD_DIV=4)
REQ-028 Reset, then idle 50 cycles -> tx_o=1, ready_o=1, busy_o=0 throughout.
REQ-029 word_i=0x1234ABCF, NEWLINE=1 -> decoded bytes 31 32 33 34 41 42 43 46 0D 0A; ready_o reasserts exactly 400 cycles after acceptance.
REQ-030 word_i=0x00000000, NEWLINE=0 -> eight 0x30 bytes; busy for 320 cycles; no CR/LF.
REQ-031 0xFFFFFFFF accepted, then valid_i held with 0x11111111 throughout -> first word sends eight 0x46, second word is accepted on the ready cycle, and its start bit follows with zero idle gap.
REQ-032 rst asserted during the 3rd data bit of the 2nd character -> tx_o=1 and ready_o=1 the next cycle; then word 0xDEADBEEF transmits fully and correctly (44 45 41 44 42 45 45 46 0D 0A).
REQ-033 Every bit sampled at mid-period by the bench model SHALL match; any framing error fails the test.

Source files
------------

// File: rtl/sm_uart_pkg.sv
// Shared definitions for the word-to-hex UART transmitter: divisor helper, ASCII constants,
// serialiser state encoding and character selection.
package sm_uart_pkg;

  localparam logic [7:0] AsciiZero   = 8'h30;
  localparam logic [7:0] AsciiUpperA = 8'h41;
  localparam logic [7:0] AsciiCr     = 8'h0D;
  localparam logic [7:0] AsciiLf     = 8'h0A;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  // Cycles per bit; results below 2 are not supported by the serialiser.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (AsciiZero + {4'h0, nib}) : (AsciiUpperA + {4'h0, nib} - 8'd10);
  endfunction

  // Character idx of a word's frame sequence: 0..7 hex digits MSN first, 8 CR, 9 LF.
  function automatic logic [7:0] word_char(input logic [31:0] word, input logic [3:0] idx);
    logic [4:0] base;
    base = 5'd28 - {idx[2:0], 2'b00};
    if (idx == 4'd8) return AsciiCr;
    if (idx == 4'd9) return AsciiLf;
    return hex_ascii(word[base +: 4]);
  endfunction

endpackage

// File: rtl/sm_uart_tx_byte.sv
// 8N1 byte serialiser. done_o marks the last cycle of the stop bit; a start_i in that cycle
// chains the next frame with no idle gap.
module sm_uart_tx_byte
  import sm_uart_pkg::*;
#(
  parameter int unsigned BaudDiv = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  output logic       tx_o,
  output logic       done_o
);

  localparam int unsigned CntW = $clog2(BaudDiv);
  localparam logic [CntW-1:0] CntMax = CntW'(BaudDiv - 1);

  tx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            bit_end;

  assign bit_end = (cnt_q == CntMax);
  assign done_o  = (state_q == StStop) && bit_end;
  assign tx_o    = tx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    if (state_q != StIdle) cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StStart;
          tx_d    = 1'b0;
          shift_d = byte_i;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          if (start_i) begin
            state_d = StStart;
            tx_d    = 1'b0;
            shift_d = byte_i;
          end else begin
            state_d = StIdle;
            tx_d    = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/sm_uart_word_tx.sv
// Sends a 32-bit word as eight uppercase hex characters (optionally CR LF) over 8N1 UART.
// Characters are chained into the byte serialiser on its done cycle.
module sm_uart_word_tx
  import sm_uart_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100000000,
  parameter int unsigned BAUD    = 115200,
  parameter bit          NEWLINE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] word_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        tx_o,
  output logic        busy_o
);

  localparam int unsigned BaudDiv = baud_div(CLK_HZ, BAUD);
  localparam logic [3:0]  LastIdx = NEWLINE ? 4'd9 : 4'd7;

  logic        ready_q, ready_d;
  logic [31:0] word_q, word_d;
  logic [3:0]  idx_q, idx_d;
  logic        byte_start;
  logic        byte_done;
  logic [7:0]  byte_val;

  always_comb begin
    ready_d    = ready_q;
    word_d     = word_q;
    idx_d      = idx_q;
    byte_start = 1'b0;
    // First character comes straight from word_i so its start bit lands the next cycle.
    byte_val   = word_char(word_i, 4'd0);
    if (ready_q) begin
      if (valid_i) begin
        ready_d    = 1'b0;
        word_d     = word_i;
        idx_d      = '0;
        byte_start = 1'b1;
      end
    end else if (byte_done) begin
      if (idx_q == LastIdx) begin
        ready_d = 1'b1;
        idx_d   = '0;
      end else begin
        idx_d      = idx_q + 4'd1;
        byte_start = 1'b1;
        byte_val   = word_char(word_q, idx_q + 4'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b1;
      word_q  <= '0;
      idx_q   <= '0;
    end else begin
      ready_q <= ready_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
    end
  end

  sm_uart_tx_byte #(
    .BaudDiv(BaudDiv)
  ) u_tx_byte (
    .clk    (clk),
    .rst    (rst),
    .start_i(byte_start),
    .byte_i (byte_val),
    .tx_o   (tx_o),
    .done_o (byte_done)
  );

  assign ready_o = ready_q;
  assign busy_o  = ~ready_q;

endmodule

// File: tb/tb_sm_uart_word_tx.sv
// Bench for sm_uart_word_tx: two instances (with and without CR/LF), a waveform-queue model,
// a mid-bit UART receiver and directed plus random word traffic.
module tb_sm_uart_word_tx;

  localparam int D = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0][31:0] word;
  logic [1:0]       valid;
  logic [1:0]       ready;
  logic [1:0]       tx;
  logic [1:0]       busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sm_uart_word_tx #(.CLK_HZ(400), .BAUD(100), .NEWLINE(1'b1)) u_dut_nl (
    .clk(clk), .rst(rst), .word_i(word[0]), .valid_i(valid[0]),
    .ready_o(ready[0]), .tx_o(tx[0]), .busy_o(busy[0])
  );

  sm_uart_word_tx #(.CLK_HZ(400), .BAUD(100), .NEWLINE(1'b0)) u_dut_raw (
    .clk(clk), .rst(rst), .word_i(word[1]), .valid_i(valid[1]),
    .ready_o(ready[1]), .tx_o(tx[1]), .busy_o(busy[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 10) ? 8'(48 + int'(n)) : 8'(65 + int'(n) - 10);
  endfunction

  function automatic logic [7:0] char_of(input logic [31:0] w, input int c);
    if (c == 8) return 8'h0D;
    if (c == 9) return 8'h0A;
    return hex_char(w[31 - 4*c -: 4]);
  endfunction

  // Model: per instance, the tx level for each remaining busy cycle; empty means ready.
  bit         mq    [2][$];
  logic [7:0] erx   [2][$];
  logic [7:0] rxlog [2][$];
  int         rs    [2] = '{0, 0};
  int         rc    [2] = '{0, 0};
  logic [7:0] rsh   [2];
  logic       rst_seen;

  task automatic load(input int i, input logic [31:0] w);
    int  n;
    logic [7:0] ch;
    bit  lvl;
    n = (i == 0) ? 10 : 8;
    for (int c = 0; c < n; c++) begin
      ch = char_of(w, c);
      erx[i].push_back(ch);
      for (int s = 0; s < 10; s++) begin
        lvl = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : ch[s-1];
        for (int r = 0; r < D; r++) mq[i].push_back(lvl);
      end
    end
  endtask

  always begin
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mq[i].delete();
        erx[i].delete();
      end else if (mq[i].size() == 0) begin
        if (valid[i]) load(i, word[i]);
      end else begin
        void'(mq[i].pop_front());
      end
    end
    rst_seen = rst;
    #1;
    for (int i = 0; i < 2; i++) begin
      logic exp_tx;
      logic exp_rdy;
      int   k;
      exp_rdy = (mq[i].size() == 0);
      exp_tx  = exp_rdy ? 1'b1 : mq[i][0];
      check($sformatf("tx%0d", i), tx[i], exp_tx);
      check($sformatf("ready%0d", i), ready[i], exp_rdy);
      check($sformatf("busy%0d", i), busy[i], !exp_rdy);
      // Receiver sampling each bit at mid-period.
      if (rst_seen) begin
        rs[i] = 0;
      end else if (rs[i] == 0) begin
        if (tx[i] == 1'b0) begin
          rs[i] = 1;
          rc[i] = 0;
        end
      end else begin
        rc[i]++;
        if (rc[i] >= D/2 && (rc[i] - D/2) % D == 0) begin
          k = (rc[i] - D/2) / D;
          if (k == 0) begin
            check($sformatf("start bit%0d", i), tx[i], 1'b0);
          end else if (k <= 8) begin
            rsh[i][k-1] = tx[i];
          end else begin
            check($sformatf("stop bit%0d", i), tx[i], 1'b1);
            rxlog[i].push_back(rsh[i]);
            if (erx[i].size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL rx%0d unexpected byte: got %0h expected none", i, rsh[i]);
            end else begin
              check($sformatf("rx byte%0d", i), rsh[i], erx[i].pop_front());
            end
            rs[i] = 0;
          end
        end
      end
    end
  end

  task automatic wait_both(output int lat0, output int lat1);
    lat0 = -1;
    lat1 = -1;
    for (int cyc = 1; cyc <= 1500; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready[0] && lat0 < 0) lat0 = cyc;
      if (ready[1] && lat1 < 0) lat1 = cyc;
      if (lat0 >= 0 && lat1 >= 0) break;
    end
  endtask

  task automatic cmp_log(input int i, input string name, input logic [7:0] e[$]);
    check({name, " count"}, rxlog[i].size(), e.size());
    for (int k = 0; k < e.size() && k < rxlog[i].size(); k++) check(name, rxlog[i][k], e[k]);
    rxlog[i].delete();
  endtask

  initial begin
    int lat0, lat1;
    logic [7:0] e[$];
    rst   = 1'b1;
    valid = '0;
    word  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      check("idle tx", tx, 2'b11);
      check("idle ready", ready, 2'b11);
      check("idle busy", busy, 2'b00);
    end

    // 0x1234ABCF with CR/LF, and all-zero word without.
    word[0] = 32'h1234ABCF;
    word[1] = 32'h0000_0000;
    valid   = 2'b11;
    @(negedge clk);
    valid = 2'b00;
    check("accept ready", ready, 2'b00);
    check("first start", tx, 2'b00);
    wait_both(lat0, lat1);
    check("busy time nl", lat0, 400);
    check("busy time raw", lat1, 320);
    e = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h46, 8'h0D, 8'h0A};
    cmp_log(0, "bytes 1234ABCF", e);
    e = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30};
    cmp_log(1, "bytes 00000000", e);

    // Random words, with valid pulses while busy that must be ignored.
    for (int t = 0; t < 6; t++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      word[0] = $urandom;
      word[1] = $urandom;
      valid   = 2'($urandom_range(1, 3));
      for (int cyc = 0; cyc < 1500; cyc++) begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
          if (ready[i]) begin
            valid[i] = 1'b0;
          end else begin
            valid[i] = 1'($urandom_range(0, 1));
            word[i]  = $urandom;
          end
        end
        if (ready == 2'b11) break;
      end
      check("random done", ready, 2'b11);
    end
    rxlog[0].delete();
    rxlog[1].delete();

    // Back-to-back: valid held high across the ready cycle.
    @(negedge clk);
    word[0]  = 32'hFFFFFFFF;
    valid[0] = 1'b1;
    @(negedge clk);
    word[0] = 32'h11111111;
    check("b2b busy", ready[0], 1'b0);
    wait_both(lat0, lat1);
    check("b2b first busy time", lat0, 400);
    check("b2b ready cycle tx", tx[0], 1'b1);
    @(negedge clk);
    check("b2b accepted", ready[0], 1'b0);
    check("b2b start no gap", tx[0], 1'b0);
    valid[0] = 1'b0;
    wait_both(lat0, lat1);
    check("b2b second busy time", lat0, 400);
    e.delete();
    for (int k = 0; k < 8; k++) e.push_back(8'h46);
    e.push_back(8'h0D);
    e.push_back(8'h0A);
    for (int k = 0; k < 8; k++) e.push_back(8'h31);
    e.push_back(8'h0D);
    e.push_back(8'h0A);
    cmp_log(0, "bytes b2b", e);

    // Reset during data bit 2 of the second character; valid on the other instance ignored.
    @(negedge clk);
    word[0]  = 32'h5A5A5A5A;
    valid[0] = 1'b1;
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (53) @(negedge clk);
    check("pre-reset busy", ready[0], 1'b0);
    rst      = 1'b1;
    word[1]  = 32'h12345678;
    valid[1] = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    valid[1] = 1'b0;
    check("abort tx", tx, 2'b11);
    check("abort ready", ready, 2'b11);
    check("abort busy", busy, 2'b00);
    @(negedge clk);
    check("rst beats valid", ready[1], 1'b1);
    e = '{8'h35};
    cmp_log(0, "bytes before abort", e);
    e.delete();
    cmp_log(1, "bytes raw after rst", e);

    word[0]  = 32'hDEADBEEF;
    valid[0] = 1'b1;
    @(negedge clk);
    valid[0] = 1'b0;
    wait_both(lat0, lat1);
    check("deadbeef busy time", lat0, 400);
    e = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    cmp_log(0, "bytes DEADBEEF", e);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
